// File: rtl/pe_pkg.sv
// Shared types and defaults for the convolution-lane product feeder.
package pe_pkg;

  // Feeder control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2
  } feeder_state_e;

  localparam int PE_DATA_W    = 8;   // signed IFM pixel width
  localparam int PE_WGT_W     = 8;   // signed weight width
  localparam int PE_PROD_W    = 20;  // product / bias width to adder tree
  localparam int KERNEL_WORDS = 10;  // 9 weights + 1 bias

endpackage

// File: rtl/pe_line_buffer.sv
// One image row of delay: a DEPTH-deep enabled shift buffer.
// dout_o is the value written DEPTH enables ago; it is read before the shift,
// so the same enable that consumes it also pushes the new sample in.
module pe_line_buffer #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [DEPTH-1:0][W-1:0] sr_q;

  // Contents need no reset: every slot is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (en_i) sr_q <= {sr_q[DEPTH-2:0], din_i};
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pe_product_feeder.sv
// Convolution lane front end: kernel/bias load, 3x3 sliding window over a
// raster IFM stream, registered element-wise products for the adder tree.
// Optional: define PE_FEEDER_OFM_VALID_EN to add ofm_valid, a 4-cycle delayed
// copy of product_valid aligned to the adder tree's register stages.
module pe_product_feeder import pe_pkg::*; #(
  parameter int DATA_W      = PE_DATA_W,
  parameter int WGT_W       = PE_WGT_W,
  parameter int PROD_W      = PE_PROD_W,
  parameter int PE_ARR_SIZE = 9,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               w_valid,
  input  logic [PROD_W-1:0]                  w_data,
  input  logic                               pixel_valid,
  input  logic [DATA_W-1:0]                  pixel_data,
  output logic                               pixel_ready,
  output logic [PE_ARR_SIZE-1:0][PROD_W-1:0] product_output,
  output logic [PROD_W-1:0]                  bias_output,
  output logic                               product_valid,
`ifdef PE_FEEDER_OFM_VALID_EN
  output logic                               ofm_valid,
`endif
  output logic                               frame_done,
  output logic                               busy
);

  localparam int CW = (IMG_W > IMG_H) ? $clog2(IMG_W) : $clog2(IMG_H);

  feeder_state_e                     state_q, state_d;
  logic [3:0]                        wcnt_q;
  logic [CW-1:0]                     col_q, row_q;
  logic [PE_ARR_SIZE-1:0][WGT_W-1:0] kern_q;
  logic [PROD_W-1:0]                 bias_q;
  logic [PE_ARR_SIZE-1:0][DATA_W-1:0] win_q;
  logic [PE_ARR_SIZE-1:0][PROD_W-1:0] prod_q, prod_d;
  logic                              win_vld_q, win_last_q;
  logic                              prod_vld_q, frame_done_q;
  logic [DATA_W-1:0]                 lb0_out, lb1_out;
  logic [2:0][DATA_W-1:0]            new_col;
  logic                              accept, col_wrap, row_last, win_done, last_win;

  assign pixel_ready = (state_q == STREAM);
  assign busy        = (state_q != IDLE);
  assign accept      = pixel_ready && pixel_valid;
  assign col_wrap    = (col_q == CW'(IMG_W - 1));
  assign row_last    = (row_q == CW'(IMG_H - 1));
  assign win_done    = accept && (row_q >= CW'(2)) && (col_q >= CW'(2));
  assign last_win    = win_done && col_wrap && row_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: load exactly KERNEL_WORDS words, stream until the last window
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (w_valid && wcnt_q == 4'(KERNEL_WORDS - 1)) state_d = STREAM;
      STREAM:  if (frame_done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Kernel / bias capture; word index KERNEL_WORDS-1 is the full-width bias
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      kern_q <= '0;
      bias_q <= '0;
    end else if (state_q != LOAD_W) begin
      wcnt_q <= '0;
    end else if (w_valid) begin
      wcnt_q <= wcnt_q + 4'd1;
      if (wcnt_q == 4'(KERNEL_WORDS - 1)) bias_q <= w_data;
      else                                kern_q[wcnt_q] <= w_data[WGT_W-1:0];
    end
  end

  // Raster position of the pixel being accepted; cleared outside STREAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state_q != STREAM) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + CW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Two rows of history: lb0 holds the previous row, lb1 the one before it
  pe_line_buffer #(.W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk_i(clk), .en_i(accept), .din_i(pixel_data), .dout_o(lb0_out)
  );
  pe_line_buffer #(.W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk_i(clk), .en_i(accept), .din_i(lb0_out), .dout_o(lb1_out)
  );

  // Right column entering the window: top = oldest row, bottom = live pixel
  assign new_col[0] = lb1_out;
  assign new_col[1] = lb0_out;
  assign new_col[2] = pixel_data;

  // Window shifts left on each accept; valid flags pulse only on accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      win_vld_q  <= win_done;
      win_last_q <= last_win;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r*3+0] <= win_q[r*3+1];
          win_q[r*3+1] <= win_q[r*3+2];
          win_q[r*3+2] <= new_col[r];
        end
      end
    end
  end

  // Signed multiply per lane; operands sign-extended to PROD_W so no overflow
  for (genvar k = 0; k < PE_ARR_SIZE; k++) begin : g_mul
    logic signed [PROD_W-1:0] px_ext, wt_ext;
    assign px_ext    = {{(PROD_W-DATA_W){win_q[k][DATA_W-1]}}, win_q[k]};
    assign wt_ext    = {{(PROD_W-WGT_W){kern_q[k][WGT_W-1]}}, kern_q[k]};
    assign prod_d[k] = px_ext * wt_ext;
  end

  // Product register, valid and end-of-frame pulse, one edge behind the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      prod_vld_q   <= win_vld_q;
      frame_done_q <= win_vld_q && win_last_q;
      if (win_vld_q) prod_q <= prod_d;
    end
  end

  assign product_output = prod_q;
  assign bias_output    = bias_q;
  assign product_valid  = prod_vld_q;
  assign frame_done     = frame_done_q;

`ifdef PE_FEEDER_OFM_VALID_EN
  logic [3:0] vld_pipe_q;

  // Delay line matching the adder tree's four register stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[2:0], prod_vld_q};
  end

  assign ofm_valid = vld_pipe_q[3];
`endif

endmodule

// File: tb/tb_pe_product_feeder.sv
// Scoreboard bench for pe_product_feeder on a 4x4 frame.
module tb_pe_product_feeder;

  localparam int PW = 20;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                w_valid = 1'b0;
  logic [PW-1:0]       w_data = '0;
  logic                pixel_valid = 1'b0;
  logic [7:0]          pixel_data = '0;
  logic                pixel_ready;
  logic [8:0][PW-1:0]  product_output;
  logic [PW-1:0]       bias_output;
  logic                product_valid;
  logic                frame_done;
  logic                busy;
`ifdef PE_FEEDER_OFM_VALID_EN
  logic                ofm_valid;
`endif

  pe_product_feeder #(
    .DATA_W(8), .WGT_W(8), .PROD_W(PW), .PE_ARR_SIZE(9), .IMG_W(4), .IMG_H(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_valid(w_valid), .w_data(w_data),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_ready(pixel_ready),
    .product_output(product_output), .bias_output(bias_output),
    .product_valid(product_valid),
`ifdef PE_FEEDER_OFM_VALID_EN
    .ofm_valid(ofm_valid),
`endif
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][PW-1:0] p;
    logic               fd;
    int                 due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [179:0] act, input logic [179:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per product_valid and compare
  always @(negedge clk) begin
    exp_t e;
    if (product_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_product: got %h expected none", product_output);
      end else begin
        e = q.pop_front();
        chk("products", product_output, e.p);
        chk("frame_done", frame_done, e.fd);
        chk("latency", cyc, e.due);
      end
    end else if (frame_done) begin
      checks++; errors++;
      $display("FAIL stray_frame_done: got 1 expected 0");
    end
  end

`ifdef PE_FEEDER_OFM_VALID_EN
  logic [3:0] pv_hist = '0;
  // ofm_valid must replay product_valid four cycles later
  always @(negedge clk) begin
    if (!rst_n) pv_hist <= '0;
    else begin
      if (ofm_valid || pv_hist[3]) chk("ofm_valid", ofm_valid, pv_hist[3]);
      pv_hist <= {pv_hist[2:0], product_valid};
    end
  end
`endif

  // Hand table: window k of the 1..16 ramp has top-left pixel tl[k]
  function automatic logic [8:0][PW-1:0] exp_ramp(input int k);
    int tl [4] = '{1, 2, 5, 6};
    logic [8:0][PW-1:0] v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[r*3+c] = PW'(tl[k] + r*4 + c);
    return v;
  endfunction

  function automatic logic [8:0][PW-1:0] exp_center();
    logic [8:0][PW-1:0] v;
    v    = '0;
    v[4] = 20'hFC080;  // 127 * -128 = -16256
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // kmode 0: all weights 1; kmode 1: only position 4 = -128
  task automatic load(input int kmode, input logic [PW-1:0] bias);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w_valid = 1'b1;
      if (i == 9)         w_data = bias;
      else if (kmode == 0) w_data = 20'd1;
      else                w_data = (i == 4) ? 20'h00080 : 20'd0;
      tick();
    end
    w_valid = 1'b0;
    chk("pixel_ready_after_load", pixel_ready, 1'b1);
    chk("bias_output", bias_output, bias);
  endtask

  // pmode 0: ramp 1..16, pmode 1: constant 127
  task automatic stream(input int pmode, input int kmode, input bit gaps,
                        input bit pulse_start, input int npix);
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      pixel_valid = 1'b1;
      pixel_data  = (pmode == 0) ? 8'(i + 1) : 8'd127;
      start       = pulse_start && (i == 5);
      if ((i / 4) >= 2 && (i % 4) >= 2) begin
        e.p   = (kmode == 0) ? exp_ramp((i/4 - 2)*2 + (i%4 - 2)) : exp_center();
        e.fd  = (i == 15);
        e.due = cyc + 2;
        q.push_back(e);
      end
      tick();
      start = 1'b0;
      if (gaps) begin pixel_valid = 1'b0; tick(); end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin tick(); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    tick(); tick();
    chk("busy_after_frame", busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel_ready", pixel_ready, 1'b0);
    chk("rst_product_valid", product_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_products", product_output, '0);
    chk("rst_bias", bias_output, '0);
    rst_n = 1'b1;
    tick();

    // Ramp frame, unit weights, bias 5
    load(0, 20'd5);
    chk("busy_stream", busy, 1'b1);
    stream(0, 0, 1'b0, 1'b0, 16);
    drain();

    // Extreme signed product in the centre tap, negative bias
    load(1, 20'hFFFFD);
    stream(1, 1, 1'b0, 1'b0, 16);
    drain();

    // Valid gaps plus a start pulse mid-stream
    load(0, 20'd5);
    stream(0, 0, 1'b1, 1'b1, 16);
    drain();

    // Abandon a frame with reset after 7 pixels
    load(0, 20'd5);
    stream(0, 0, 1'b0, 1'b0, 7);
    rst_n = 1'b0; #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_pixel_ready", pixel_ready, 1'b0);
    chk("midrst_products", product_output, '0);
    chk("midrst_bias", bias_output, '0);
    tick(); rst_n = 1'b1; tick();
    pixel_valid = 1'b1; pixel_data = 8'd99;
    repeat (3) tick();
    chk("idle_pixel_ready", pixel_ready, 1'b0);
    pixel_valid = 1'b0;
    load(0, 20'd5);
    stream(0, 0, 1'b0, 1'b0, 16);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_product_feeder.md
# pe_product_feeder

Front end of one convolution lane. It loads a 3x3 kernel and a bias, then streams an IFM frame in raster order through two line buffers to form sliding 3x3 windows. Each window is multiplied element-wise by the kernel, and the nine registered products plus the bias are presented to the adder tree as product_output[8:0] and bias_output. The block covers valid-only convolution (no padding) and cannot be stalled from downstream.

## Interface
- DATA_W, 8, signed IFM pixel width
- WGT_W, 8, signed weight width
- PROD_W, 20, product/bias width handed to the adder tree
- PE_ARR_SIZE, 9, products per window (fixed 3x3)
- IMG_W, 8, frame width in pixels (≥3)
- IMG_H, 8, frame height in pixels (≥3)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin kernel load; honoured only in IDLE
- w_valid  input  1  weight/bias word present
- w_data  input  PROD_W  words 0..8 = kernel (low WGT_W bits, row-major); word 9 = bias (full width)
- pixel_valid  input  1  pixel present
- pixel_data  input  DATA_W  raster-order pixel
- pixel_ready  output  1  high throughout STREAM
- product_output  output  PROD_W x PE_ARR_SIZE  registered products; index 0 = window top-left, 8 = bottom-right
- bias_output  output  PROD_W  loaded bias, stable after LOAD_W
- product_valid  output  1  product_output holds a new window
- ofm_valid  output  1  (only with macro) adder-tree result valid
- frame_done  output  1  one-cycle pulse on the last window of a frame
- busy  output  1  state != IDLE

## Operation
- FSM IDLE -> LOAD_W on start. LOAD_W captures one word per w_valid cycle through a 4-bit counter and moves to STREAM after word 9. STREAM -> IDLE on the cycle frame_done is issued.
- In STREAM, an accept is pixel_valid && pixel_ready. Each accept shifts the 3x3 window left and writes the new pixel into line buffer 0. The pixel evicted from line buffer 0 goes into line buffer 1, and each line-buffer read column fills the window's right column.
- col/row counters advance per accept. col wraps at IMG_W-1, and row increments on each wrap.
- An accept with row≥2 and col≥2 marks a complete window. Each complete window produces one product vector, (IMG_H-2)*(IMG_W-2) per frame.
- Product arithmetic: signed DATA_W x signed WGT_W, sign-extended to PROD_W. No saturation, since DATA_W+WGT_W ≤ PROD_W is required.
- Gaps in pixel_valid freeze all counters and windows. product_valid stays low during a gap.
- start outside IDLE and w_valid outside LOAD_W are ignored.
- Reset mid-frame returns the FSM to IDLE and clears the counters and the kernel. The frame is abandoned, and any further pixels are dropped with pixel_ready=0.
- Reset values: pixel_ready, product_valid, ofm_valid, frame_done and busy are 0. product_output and bias_output are all 0. Line-buffer contents are don't-care; they are overwritten before use.

## Timing
- The window register updates on the accept edge N, and the product register on edge N+1. product_valid is high in the cycle after edge N+1, giving a 2-cycle latency from accept to product.
- frame_done is coincident with the last product_valid. busy falls on the following edge.
- pixel_ready rises on the first cycle of STREAM, which is the edge after word 9 is captured.
- Throughput is one window per clock when pixel_valid is held high.

## Configuration
- PE_FEEDER_OFM_VALID_EN defined: a 4-deep shift register delays product_valid, so ofm_valid is high exactly 4 cycles after each product_valid. This matches the adder tree's four register stages.
- Not defined: the ofm_valid port and the shift register are absent, and downstream derives its own timing.

## Structure
- Shared package pe_pkg:
  - feeder state enum (IDLE, LOAD_W, STREAM)
  - DATA_W, WGT_W and PROD_W defaults
  - KERNEL_WORDS = 10
- Sub-module pe_line_buffer: a single-clock IMG_W-deep shift buffer with an enable. It is instantiated twice.

## Test plan
- 4x4 frame, pixels 1..16, all weights 1, bias 5: 4 product vectors, the first {1,2,3,5,6,7,9,10,11}; bias_output = 5; frame_done with the 4th vector.
- Pixel 127 with weight -128 in position 4: product_output[4] = -16256 sign-extended to 20 bits.
- pixel_valid toggling 1/0 on the 4x4 frame: the same 4 vectors, each 2 cycles after its completing accept, with none during gaps.
- start pulsed during STREAM: no effect; the frame completes normally.
- rst_n low after 7 pixels: all outputs 0 and FSM IDLE. A new start and full frame then give the correct 4 vectors.
- With PE_FEEDER_OFM_VALID_EN defined: ofm_valid follows each product_valid by exactly 4 cycles (4 pulses for 4x4).
